// File: rtl/mipi_rx_pkg.sv
// Shared types and constants for the MIPI receive lane controller.
package mipi_rx_pkg;

  typedef enum logic [2:0] {
    StWaitStop,
    StStop,
    StHsRqst,
    StHsSettle,
    StHsSync,
    StHsData
  } rx_state_e;

  // LP line codes, {DP, DN}
  localparam logic [1:0] Lp11 = 2'b11;
  localparam logic [1:0] Lp10 = 2'b10;
  localparam logic [1:0] Lp01 = 2'b01;
  localparam logic [1:0] Lp00 = 2'b00;

  localparam logic [7:0] SyncWordDefault = 8'hB8;

  // Returns {found, offset}. Scans from the top so the lowest matching offset is kept.
  function automatic logic [3:0] find_sync(input logic [15:0] win, input logic [7:0] word);
    logic [3:0] res;
    res = '0;
    for (int k = 7; k >= 0; k--) begin
      if (win[k +: 8] == word) res = {1'b1, 3'(k)};
    end
    return res;
  endfunction

endpackage

// File: rtl/mipi_lp_filter.sv
// LP line pair synchroniser plus run-length glitch filter.
module mipi_lp_filter #(
  parameter int unsigned LP_FILTER = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] lp_i,
  output logic [1:0] lp_o
);

  logic [1:0] sync1_q, sync2_q, cand_q, lp_q, lp_d;
  logic [3:0] cnt_q, cnt_d;

  // Count consecutive identical synchronised samples; accept once the run is long enough.
  always_comb begin
    cnt_d = 4'd1;
    if (sync2_q == cand_q) cnt_d = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
    lp_d = lp_q;
    if (cnt_d >= 4'(LP_FILTER)) lp_d = sync2_q;
  end

  // Synchroniser flops and filter state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      cnt_q   <= '0;
      lp_q    <= '0;
    end else begin
      sync1_q <= lp_i;
      sync2_q <= sync1_q;
      cand_q  <= sync2_q;
      cnt_q   <= cnt_d;
      lp_q    <= lp_d;
    end
  end

  assign lp_o = lp_q;

endmodule

// File: rtl/mipi_rx_lane.sv
// MIPI receive lane: SoT detection on the LP pair, HS settle, sync search/alignment, payload out.
module mipi_rx_lane import mipi_rx_pkg::*; #(
  parameter logic [7:0]  SYNC_WORD     = SyncWordDefault,
  parameter int unsigned LP_FILTER     = 2,
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned SYNC_TIMEOUT  = 32
) (
  input  logic       CLK_IN,
  input  logic       RST,
  input  logic       RX_LP_DP,
  input  logic       RX_LP_DN,
  input  logic [7:0] HS_RAW_DATA,
  input  logic       HS_RAW_VALID,
  output logic       HS_EN,
  output logic       RX_ODT_EN,
  output logic       LP_RX_DP,
  output logic       LP_RX_DN,
  output logic [7:0] HS_RX_DATA,
  output logic       HS_RX_VALID,
  output logic       HS_ACTIVE,
  output logic       STOP_STATE,
  output logic       ERR_SOT_SYNC,
  output logic       ERR_CONTROL
);

  logic [1:0]  lp;
  rx_state_e   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  prev_q, prev_d;
  logic [2:0]  k_q, k_d;
  logic [7:0]  rx_data_q, rx_data_d;
  logic        rx_valid_q, rx_valid_d;
  logic        err_sync_q, err_sync_d;
  logic        err_ctl_q, err_ctl_d;
  logic [15:0] window;
  logic [3:0]  match;
  logic        lp_stop, hs_on;

  mipi_lp_filter #(
    .LP_FILTER(LP_FILTER)
  ) u_lp_filter (
    .clk_i(CLK_IN),
    .rst_i(RST),
    .lp_i ({RX_LP_DP, RX_LP_DN}),
    .lp_o (lp)
  );

  assign window  = {HS_RAW_DATA, prev_q};
  assign match   = find_sync(window, SYNC_WORD);
  assign lp_stop = (lp == Lp11);

  // Lane FSM, shared settle/timeout counter, aligner and output byte.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prev_d     = prev_q;
    k_d        = k_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    err_sync_d = 1'b0;
    err_ctl_d  = 1'b0;
    unique case (state_q)
      StWaitStop: if (lp_stop) state_d = StStop;
      StStop:     if (lp == Lp01) state_d = StHsRqst;
      StHsRqst: begin
        case (lp)
          Lp00: begin
            state_d = StHsSettle;
            cnt_d   = '0;
          end
          Lp11: state_d = StStop;
          Lp10: begin
            err_ctl_d = 1'b1;
            state_d   = StWaitStop;
          end
          default: state_d = StHsRqst;
        endcase
      end
      StHsSettle: begin
        if (lp_stop) begin
          state_d = StStop;
        end else if (cnt_q == 8'(SETTLE_CYCLES - 1)) begin
          state_d = StHsSync;
          cnt_d   = '0;
          prev_d  = '0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StHsSync: begin
        if (lp_stop) begin
          state_d = StStop;
        end else if (HS_RAW_VALID) begin
          prev_d = HS_RAW_DATA;
          if (match[3]) begin
            k_d     = match[2:0];
            state_d = StHsData;
          end else if (cnt_q == 8'(SYNC_TIMEOUT - 1)) begin
            err_sync_d = 1'b1;
            state_d    = StWaitStop;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StHsData: begin
        if (lp_stop) begin
          state_d = StStop;
        end else if (HS_RAW_VALID) begin
          prev_d     = HS_RAW_DATA;
          rx_data_d  = window[k_q +: 8];
          rx_valid_d = 1'b1;
        end
      end
      default: state_d = StWaitStop;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK_IN) begin
    if (RST) begin
      state_q    <= StWaitStop;
      cnt_q      <= '0;
      prev_q     <= '0;
      k_q        <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      err_sync_q <= 1'b0;
      err_ctl_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prev_q     <= prev_d;
      k_q        <= k_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      err_sync_q <= err_sync_d;
      err_ctl_q  <= err_ctl_d;
    end
  end

  // Filtered LP=11 drops the HS front end in the same cycle, ahead of the state change.
  assign hs_on        = (state_q == StHsSettle) || (state_q == StHsSync) || (state_q == StHsData);
  assign HS_EN        = hs_on && !lp_stop;
  assign RX_ODT_EN    = hs_on && !lp_stop;
  assign HS_ACTIVE    = (state_q == StHsData) && !lp_stop;
  assign STOP_STATE   = (state_q == StStop);
  assign LP_RX_DP     = lp[1];
  assign LP_RX_DN     = lp[0];
  assign HS_RX_DATA   = rx_data_q;
  assign HS_RX_VALID  = rx_valid_q;
  assign ERR_SOT_SYNC = err_sync_q;
  assign ERR_CONTROL  = err_ctl_q;

endmodule

// File: tb/tb_mipi_rx_lane.sv
// Self-checking bench for mipi_rx_lane: directed LP sequences plus a payload scoreboard.
module tb_mipi_rx_lane;

  localparam int unsigned LpFilter = 2;
  localparam int unsigned Settle   = 4;
  localparam int unsigned Timeout  = 32;

  logic       clk = 1'b0;
  logic       rst;
  logic       dp, dn;
  logic [7:0] raw;
  logic       raw_valid;
  logic       hs_en, rx_odt_en, lp_rx_dp, lp_rx_dn, hs_rx_valid, hs_active, stop_state;
  logic       err_sot_sync, err_control;
  logic [7:0] hs_rx_data;

  int         n_vec = 0;
  int         n_err = 0;
  int         sot_err_cnt = 0;
  int         ctl_err_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] pl[16];

  always #5 clk = ~clk;

  mipi_rx_lane #(
    .SYNC_WORD    (8'hB8),
    .LP_FILTER    (LpFilter),
    .SETTLE_CYCLES(Settle),
    .SYNC_TIMEOUT (Timeout)
  ) dut (
    .CLK_IN      (clk),
    .RST         (rst),
    .RX_LP_DP    (dp),
    .RX_LP_DN    (dn),
    .HS_RAW_DATA (raw),
    .HS_RAW_VALID(raw_valid),
    .HS_EN       (hs_en),
    .RX_ODT_EN   (rx_odt_en),
    .LP_RX_DP    (lp_rx_dp),
    .LP_RX_DN    (lp_rx_dn),
    .HS_RX_DATA  (hs_rx_data),
    .HS_RX_VALID (hs_rx_valid),
    .HS_ACTIVE   (hs_active),
    .STOP_STATE  (stop_state),
    .ERR_SOT_SYNC(err_sot_sync),
    .ERR_CONTROL (err_control)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, 32'({hs_en, rx_odt_en, lp_rx_dp, lp_rx_dn, hs_rx_data, hs_rx_valid, hs_active,
                  stop_state, err_sot_sync, err_control}), 32'd0);
  endtask

  // Payload scoreboard and error pulse counters.
  always @(negedge clk) begin
    if (hs_rx_valid) begin
      if (exp_q.size() == 0) chk("rx_unexpected", 32'(hs_rx_valid), 32'd0);
      else chk("rx_data", 32'(hs_rx_data), 32'(exp_q.pop_front()));
    end
    if (err_sot_sync) sot_err_cnt++;
    if (err_control) ctl_err_cnt++;
  end

  // From STOP: 01 then 00; HS_EN must rise exactly when HS_SETTLE is entered.
  task automatic sot();
    {dp, dn} = 2'b01;
    repeat (6) tick();
    {dp, dn} = 2'b00;
    repeat (4) tick();
    chk("hs_en_pre_settle", 32'(hs_en), 32'd0);
    tick();
    chk("hs_en_settle", 32'(hs_en), 32'd1);
    chk("odt_settle", 32'(rx_odt_en), 32'd1);
  endtask

  // Sync bytes offered during settle must be ignored.
  task automatic settle_phase();
    raw = 8'hB8;
    raw_valid = 1'b1;
    repeat (Settle) tick();
    raw_valid = 1'b0;
    chk("active_after_settle", 32'(hs_active), 32'd0);
  endtask

  task automatic end_burst();
    raw_valid = 1'b0;
    {dp, dn} = 2'b11;
    repeat (6) tick();
    chk("stop_after_burst", 32'(stop_state), 32'd1);
    chk("hs_en_after_burst", 32'(hs_en), 32'd0);
  endtask

  // Send k filler bits, the sync byte, then pl[0..n-1], LSB first. lp_at/rst_at < 0 disables.
  task automatic burst(input int k, input int n, input bit gaps, input int lp_at,
                       input int rst_at);
    logic [175:0] stream;
    logic [7:0]   sw;
    bit           act, proc, lp_seen;
    int           nb;
    sw = 8'hB8;
    stream = '0;
    for (int b = 0; b < 8; b++) stream[k + b] = sw[b];
    for (int p = 0; p < n; p++)
      for (int b = 0; b < 8; b++) stream[k + 8 + 8 * p + b] = pl[p][b];
    nb = n + 2;
    act = 1'b0;
    for (int j = 0; j < nb; j++) begin
      if (gaps) begin
        for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
          raw_valid = 1'b0;
          raw = 8'($urandom);
          tick();
          chk("rx_valid_idle", 32'(hs_rx_valid), 32'd0);
        end
      end
      raw = stream[8 * j +: 8];
      raw_valid = 1'b1;
      if (lp_at >= 0 && j == lp_at) {dp, dn} = 2'b11;
      if (rst_at >= 0 && j == rst_at) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        raw_valid = 1'b0;
        chk_all_zero("rst_mid_burst");
        exp_q.delete();
        return;
      end
      proc = !(lp_at >= 0 && j >= lp_at + int'(LpFilter) + 2);
      lp_seen = (lp_at >= 0 && j >= lp_at + int'(LpFilter) + 1);
      if (proc && j >= 2) exp_q.push_back(pl[j - 2]);
      if (proc && j >= 1) act = 1'b1;
      tick();
      chk("rx_valid", 32'(hs_rx_valid), 32'(proc && j >= 2));
      chk("hs_active", 32'(hs_active), 32'(act && !lp_seen));
      chk("hs_en_burst", 32'(hs_en), 32'(!lp_seen));
    end
    raw_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    {dp, dn} = 2'b11;
    raw = '0;
    raw_valid = 1'b0;

    // 1: reset and LP-11 acceptance latency
    tick();
    tick();
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    repeat (3) tick();
    chk("lp_before_latency", 32'({lp_rx_dp, lp_rx_dn}), 32'd0);
    tick();
    chk("lp_at_latency", 32'({lp_rx_dp, lp_rx_dn}), 32'd3);
    chk("stop_before_fsm", 32'(stop_state), 32'd0);
    tick();
    chk("stop_state", 32'(stop_state), 32'd1);
    chk("idle_outputs", 32'({hs_en, rx_odt_en, hs_rx_valid, hs_active, err_sot_sync,
                            err_control}), 32'd0);
    repeat (5) tick();

    // 2: SoT, sync at offset 3, payload 12 34
    pl[0] = 8'h12;
    pl[1] = 8'h34;
    sot();
    settle_phase();
    burst(3, 2, 1'b0, -1, -1);
    end_burst();

    // 3: single-cycle 01 glitch in STOP
    {dp, dn} = 2'b01;
    tick();
    {dp, dn} = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("glitch_stop", 32'({stop_state, lp_rx_dp, lp_rx_dn, hs_en}), 32'b1110);
    end

    // random offset and payload with idle gaps
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    sot();
    settle_phase();
    burst(int'($urandom_range(0, 7)), 8, 1'b1, -1, -1);
    end_burst();

    // 4: sync timeout
    sot();
    settle_phase();
    raw = 8'h00;
    raw_valid = 1'b1;
    for (int i = 0; i < int'(Timeout) - 1; i++) begin
      tick();
      chk("err_sot_early", 32'(err_sot_sync), 32'd0);
    end
    chk("hs_en_in_sync", 32'(hs_en), 32'd1);
    tick();
    chk("err_sot_pulse", 32'(err_sot_sync), 32'd1);
    chk("hs_en_after_timeout", 32'(hs_en), 32'd0);
    raw_valid = 1'b0;
    tick();
    chk("err_sot_one_cycle", 32'(err_sot_sync), 32'd0);
    chk("no_stop_after_timeout", 32'(stop_state), 32'd0);
    {dp, dn} = 2'b11;
    repeat (5) tick();
    chk("stop_after_timeout", 32'(stop_state), 32'd1);
    chk("err_sot_count", 32'(sot_err_cnt), 32'd1);

    // 5: 11 -> 01 -> 10 control error
    {dp, dn} = 2'b01;
    repeat (6) tick();
    {dp, dn} = 2'b10;
    repeat (4) tick();
    chk("err_ctl_early", 32'(err_control), 32'd0);
    tick();
    chk("err_ctl_pulse", 32'(err_control), 32'd1);
    chk("stop_on_ctl_err", 32'(stop_state), 32'd0);
    tick();
    chk("err_ctl_one_cycle", 32'(err_control), 32'd0);
    {dp, dn} = 2'b11;
    repeat (5) tick();
    chk("stop_after_ctl_err", 32'(stop_state), 32'd1);
    chk("err_ctl_count", 32'(ctl_err_cnt), 32'd1);

    // 6: LP-11 mid-payload with continuous raw bytes, then reset mid-burst
    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    sot();
    settle_phase();
    burst(int'($urandom_range(0, 7)), 10, 1'b0, 4, -1);
    end_burst();

    for (int i = 0; i < 16; i++) pl[i] = 8'($urandom);
    sot();
    settle_phase();
    burst(int'($urandom_range(0, 7)), 8, 1'b0, -1, 5);
    end_burst();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    chk("err_sot_total", 32'(sot_err_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
